map_draw: RTL and testbench



---
 rtl/game_pkg.sv | 24 ++
 rtl/map_draw_pkg.sv | 28 ++
 rtl/vga_pkg.sv | 8 +
 rtl/map_probe.sv | 72 +++++++
 rtl/map_draw.sv | 172 +++++++++++++++++
 tb/tb_map_draw.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: tile encoding, map dimensions and tile colours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    FRAME   = 3'd1,
    PLAYER1 = 3'd2,
    PLAYER2 = 3'd3,
    TEST    = 3'd4
  } tile;

  localparam int MAP_WIDTH  = 48;
  localparam int MAP_HEIGHT = 48;

  localparam logic [11:0] COLOR_EMPTY   = 12'h224;
  localparam logic [11:0] COLOR_FRAME   = 12'hFFF;
  localparam logic [11:0] COLOR_PLAYER1 = 12'hF00;
  localparam logic [11:0] COLOR_PLAYER2 = 12'h00F;
  localparam logic [11:0] COLOR_TEST    = 12'h0F0;
  localparam logic [11:0] COLOR_GRID    = 12'h446;

endpackage

// File: rtl/map_draw_pkg.sv
// Helpers local to the map renderer: probe FSM states, map index widths, tile palette.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package map_draw_pkg;
  import game_pkg::*;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_READ = 2'd1,
    P_ACK  = 2'd2
  } probe_state_t;

  // Index widths that exactly address the map dimensions.
  localparam int MAP_XW = $clog2(MAP_WIDTH);
  localparam int MAP_YW = $clog2(MAP_HEIGHT);

  function automatic logic [11:0] tile_color(tile t);
    case (t)
      EMPTY:   tile_color = COLOR_EMPTY;
      FRAME:   tile_color = COLOR_FRAME;
      PLAYER1: tile_color = COLOR_PLAYER1;
      PLAYER2: tile_color = COLOR_PLAYER2;
      TEST:    tile_color = COLOR_TEST;
      default: tile_color = COLOR_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants shared by the video pipeline blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_pkg;

  localparam int CNT_W = 11;  // width of hcount/vcount

endpackage

// File: rtl/map_probe.sv
// Request/acknowledge tile probe: reads one map cell for game logic, off-map cells read as FRAME.
// Latency: ack 2 clocks after req is sampled in IDLE; one probe per 3 clocks when req held.
// Backpressure: none; req is a level held until ack, dropping it after sampling does not abort.
//
// Ports: clk, rst_n (async, active-low); map (current tile map);
//        probe_req/probe_x/probe_y (request + tile coordinates);
//        probe_ack (one-cycle pulse), probe_tile/probe_hit (held until the next ack).
module map_probe
  import game_pkg::*;
  import map_draw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  tile        map [MAP_WIDTH][MAP_HEIGHT],
  input  logic       probe_req,
  input  logic [7:0] probe_x,
  input  logic [7:0] probe_y,
  output logic       probe_ack,
  output tile        probe_tile,
  output logic       probe_hit
);

  probe_state_t state;
  logic [7:0]   x_q;
  logic [7:0]   y_q;
  logic         in_range;
  tile          rd_tile;

  // Out-of-range cells behave as walls so movement logic needs no bounds check.
  always_comb begin
    in_range = (x_q < 8'(MAP_WIDTH)) && (y_q < 8'(MAP_HEIGHT));
    rd_tile  = FRAME;
    if (in_range) rd_tile = map[x_q[MAP_XW-1:0]][y_q[MAP_YW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= P_IDLE;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      probe_ack  <= 1'b0;
      probe_tile <= EMPTY;
      probe_hit  <= 1'b0;
    end else begin
      case (state)
        P_IDLE: begin
          probe_ack <= 1'b0;
          if (probe_req) begin
            x_q   <= probe_x;
            y_q   <= probe_y;
            state <= P_READ;
          end
        end
        P_READ: begin
          probe_tile <= rd_tile;
          probe_hit  <= (rd_tile != EMPTY);
          probe_ack  <= 1'b1;
          state      <= P_ACK;
        end
        P_ACK: begin
          probe_ack <= 1'b0;
          state     <= P_IDLE;
        end
        default: begin
          probe_ack <= 1'b0;
          state     <= P_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/map_draw.sv
// Renders the tile map into the VGA stream and hosts the tile probe for game logic.
// Latency: fixed 2 clocks for pixel and timing; probe ack 2 clocks after req is taken.
// Backpressure: none; the pixel path never stalls and the probe runs beside it.
//
// Ports: clk, rst_n (async, active-low); map (current tile map);
//        hcount/vcount/hsync/vsync/hblnk/vblnk/rgb _in -> same _out delayed 2 clocks,
//        rgb_out carries the rendered pixel; probe_req/x/y -> probe_ack/tile/hit.
// Build option: define MAP_DRAW_GRID_EN to draw grid lines on the first row/column
//               of every EMPTY tile.
module map_draw
  import game_pkg::*;
  import vga_pkg::*;
  import map_draw_pkg::*;
#(
  parameter int             TILE_SHIFT = 3,
  parameter logic [10:0]    MAP_X0     = 11'd0,
  parameter logic [10:0]    MAP_Y0     = 11'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  tile              map [MAP_WIDTH][MAP_HEIGHT],
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [11:0]      rgb_in,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out,
  input  logic             probe_req,
  input  logic [7:0]       probe_x,
  input  logic [7:0]       probe_y,
  output logic             probe_ack,
  output tile              probe_tile,
  output logic             probe_hit
);

  // ---------------- stage 1: pixel -> tile coordinates ----------------
  logic [CNT_W:0]   rel_x_ext;
  logic [CNT_W:0]   rel_y_ext;
  logic [CNT_W-1:0] rel_x;
  logic [CNT_W-1:0] rel_y;
  logic [CNT_W-1:0] tx;
  logic [CNT_W-1:0] ty;
  logic             in_map_d;

  // Subtract one bit wider so the borrow tells us hcount < MAP_X0 before the
  // 11-bit result wraps.
  always_comb begin
    rel_x_ext = {1'b0, hcount_in} - {1'b0, MAP_X0};
    rel_y_ext = {1'b0, vcount_in} - {1'b0, MAP_Y0};
    rel_x     = rel_x_ext[CNT_W-1:0];
    rel_y     = rel_y_ext[CNT_W-1:0];
    tx        = rel_x >> TILE_SHIFT;
    ty        = rel_y >> TILE_SHIFT;
    in_map_d  = !rel_x_ext[CNT_W] && !rel_y_ext[CNT_W] &&
                (tx < CNT_W'(MAP_WIDTH)) && (ty < CNT_W'(MAP_HEIGHT));
  end

  logic [MAP_XW-1:0] s1_tx;
  logic [MAP_YW-1:0] s1_ty;
  logic              s1_in_map;
  logic [11:0]       s1_rgb;
  logic [CNT_W-1:0]  s1_hcount;
  logic [CNT_W-1:0]  s1_vcount;
  logic              s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tx     <= '0;
      s1_ty     <= '0;
      s1_in_map <= 1'b0;
      s1_rgb    <= 12'h000;
      s1_hcount <= '0;
      s1_vcount <= '0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_vblnk  <= 1'b0;
    end else begin
      s1_tx     <= tx[MAP_XW-1:0];
      s1_ty     <= ty[MAP_YW-1:0];
      s1_in_map <= in_map_d;
      s1_rgb    <= rgb_in;
      s1_hcount <= hcount_in;
      s1_vcount <= vcount_in;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      s1_hblnk  <= hblnk_in;
      s1_vblnk  <= vblnk_in;
    end
  end

  // ---------------- stage 2: map read ----------------
  tile         s2_tile;
  logic        s2_in_map;
  logic [11:0] s2_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_tile    <= EMPTY;
      s2_in_map  <= 1'b0;
      s2_rgb     <= 12'h000;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else begin
      // The map is read live here: edits show on the next pixel that hits the cell.
      s2_tile    <= s1_in_map ? map[s1_tx][s1_ty] : EMPTY;
      s2_in_map  <= s1_in_map;
      s2_rgb     <= s1_rgb;
      hcount_out <= s1_hcount;
      vcount_out <= s1_vcount;
      hsync_out  <= s1_hsync;
      vsync_out  <= s1_vsync;
      hblnk_out  <= s1_hblnk;
      vblnk_out  <= s1_vblnk;
    end
  end

`ifdef MAP_DRAW_GRID_EN
  // Grid flag rides alongside the pipeline so latency is unchanged.
  logic grid_d, s1_grid, s2_grid;
  assign grid_d = (rel_x[TILE_SHIFT-1:0] == '0) || (rel_y[TILE_SHIFT-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_grid <= 1'b0;
      s2_grid <= 1'b0;
    end else begin
      s1_grid <= grid_d;
      s2_grid <= s1_grid;
    end
  end
`endif

  // ---------------- output mux ----------------
  always_comb begin
    rgb_out = s2_rgb;
    if (hblnk_out || vblnk_out) begin
      rgb_out = 12'h000;
    end else if (s2_in_map) begin
      rgb_out = tile_color(s2_tile);
`ifdef MAP_DRAW_GRID_EN
      if (s2_grid && (s2_tile == EMPTY)) rgb_out = COLOR_GRID;
`endif
    end
  end

  // ---------------- probe port ----------------
  map_probe u_probe (
    .clk        (clk),
    .rst_n      (rst_n),
    .map        (map),
    .probe_req  (probe_req),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .probe_ack  (probe_ack),
    .probe_tile (probe_tile),
    .probe_hit  (probe_hit)
  );

endmodule

// File: tb/tb_map_draw.sv
// Self-checking bench for map_draw: directed pixel table, random pixel stream
// against a reference model, probe sequences and mid-operation reset.
module tb_map_draw;
  import game_pkg::*;

  localparam int X0 = 0;
  localparam int Y0 = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  tile         map [MAP_WIDTH][MAP_HEIGHT];
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic        probe_req, probe_ack, probe_hit;
  logic [7:0]  probe_x, probe_y;
  tile         probe_tile;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  map_draw dut (
    .clk(clk), .rst_n(rst_n), .map(map),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out),
    .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y),
    .probe_ack(probe_ack), .probe_tile(probe_tile), .probe_hit(probe_hit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [11:0] ref_color(tile t);
    if (t == FRAME)   return 12'hFFF;
    if (t == PLAYER1) return 12'hF00;
    if (t == PLAYER2) return 12'h00F;
    if (t == TEST)    return 12'h0F0;
    return 12'h224;
  endfunction

  function automatic logic [11:0] ref_pixel(int h, int v, bit hb, bit vb, logic [11:0] bg);
    int  rx, ry;
    tile t;
    if (hb || vb) return 12'h000;
    rx = h - X0;
    ry = v - Y0;
    if (rx < 0 || ry < 0 || rx / 8 >= MAP_WIDTH || ry / 8 >= MAP_HEIGHT) return bg;
    t = map[rx / 8][ry / 8];
`ifdef MAP_DRAW_GRID_EN
    if (t == EMPTY && (rx % 8 == 0 || ry % 8 == 0)) return 12'h446;
`endif
    return ref_color(t);
  endfunction

  function automatic tile ref_probe(int x, int y);
    if (x >= MAP_WIDTH || y >= MAP_HEIGHT) return FRAME;
    return map[x][y];
  endfunction

  typedef struct {
    string       name;
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] bg, exp;
  } vec_t;

  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] bg;
  } pix_t;

  task automatic do_probe(input string name, input int x, input int y);
    int  got;
    tile exp_t;
    exp_t     = ref_probe(x, y);
    probe_x   = 8'(x);
    probe_y   = 8'(y);
    probe_req = 1'b1;
    got = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (probe_ack) begin
        got = c;
        break;
      end
    end
    probe_req = 1'b0;
    check({name, "_ack_latency"}, got, 2);
    check({name, "_tile"}, probe_tile, exp_t);
    check({name, "_hit"}, probe_hit, (exp_t != EMPTY));
    step();
    check({name, "_ack_one_cycle"}, probe_ack, 0);
  endtask

  vec_t vecs [9];
  pix_t q [$];

  initial begin
    int   acks;
    pix_t p, o;

    // Map: FRAME border, random interior, a few fixed cells the tests rely on.
    for (int x = 0; x < MAP_WIDTH; x++)
      for (int y = 0; y < MAP_HEIGHT; y++)
        if (x == 0 || y == 0 || x == MAP_WIDTH - 1 || y == MAP_HEIGHT - 1) map[x][y] = FRAME;
        else map[x][y] = tile'($urandom_range(0, 4));
    map[10][40] = TEST;
    map[5][6]   = PLAYER1;
    map[2][2]   = EMPTY;

    hcount_in = 11'd0; vcount_in = 11'd0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'h000; probe_req = 1'b0; probe_x = 8'd0; probe_y = 8'd0;

    // Reset state
    #3;
    check("rst_rgb", rgb_out, 0);
    check("rst_hcount", hcount_out, 0);
    check("rst_ack", probe_ack, 0);
    check("rst_probe_tile", probe_tile, EMPTY);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed pixel table
    vecs[0] = '{"tile_test",     11'd80,  11'd320, 1, 0, 0, 0, 12'h123, 12'h0F0};
    vecs[1] = '{"tile_frame",    11'd0,   11'd0,   0, 1, 0, 0, 12'h123, 12'hFFF};
    vecs[2] = '{"off_map_right", 11'd384, 11'd10,  1, 1, 0, 0, 12'hABC, 12'hABC};
    vecs[3] = '{"hblank",        11'd80,  11'd320, 0, 0, 1, 0, 12'hABC, 12'h000};
    vecs[4] = '{"vblank",        11'd40,  11'd48,  0, 0, 0, 1, 12'hABC, 12'h000};
    vecs[5] = '{"player1",       11'd43,  11'd52,  1, 0, 0, 0, 12'h321, 12'hF00};
`ifdef MAP_DRAW_GRID_EN
    vecs[6] = '{"grid_empty",    11'd16,  11'd17,  0, 0, 0, 0, 12'h321, 12'h446};
`else
    vecs[6] = '{"grid_empty",    11'd16,  11'd17,  0, 0, 0, 0, 12'h321, 12'h224};
`endif
    vecs[7] = '{"off_map_below", 11'd20,  11'd384, 0, 1, 0, 0, 12'h5A5, 12'h5A5};
    vecs[8] = '{"last_cell",     11'd383, 11'd383, 1, 1, 0, 0, 12'h777, 12'hFFF};

    for (int i = 0; i < 9; i++) begin
      hcount_in = vecs[i].h; vcount_in = vecs[i].v;
      hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
      hblnk_in = vecs[i].hb; vblnk_in = vecs[i].vb; rgb_in = vecs[i].bg;
      step();
      step();
      check({vecs[i].name, "_rgb"}, rgb_out, vecs[i].exp);
      check({vecs[i].name, "_hsync"}, hsync_out, vecs[i].hs);
      check({vecs[i].name, "_vsync"}, vsync_out, vecs[i].vs);
    end

    // Random pixel stream: every output must equal the input from 2 clocks earlier.
    q.delete();
    for (int i = 0; i < 400; i++) begin
      p.h  = 11'($urandom_range(0, 520));
      p.v  = 11'($urandom_range(0, 420));
      p.hs = 1'($urandom); p.vs = 1'($urandom);
      p.hb = ($urandom_range(0, 7) == 0); p.vb = ($urandom_range(0, 7) == 0);
      p.bg = 12'($urandom);
      hcount_in = p.h; vcount_in = p.v; hsync_in = p.hs; vsync_in = p.vs;
      hblnk_in = p.hb; vblnk_in = p.vb; rgb_in = p.bg;
      q.push_back(p);
      step();
      if (q.size() == 2) begin
        o = q.pop_front();
        check("rand_rgb", rgb_out, ref_pixel(o.h, o.v, o.hb, o.vb, o.bg));
        check("rand_hcount", hcount_out, o.h);
        check("rand_vcount", vcount_out, o.v);
        check("rand_timing", {hsync_out, vsync_out, hblnk_out, vblnk_out},
              {o.hs, o.vs, o.hb, o.vb});
      end
    end

    // Probe: directed cells, off-map wall, random cells
    do_probe("probe_p1", 5, 6);
    do_probe("probe_empty", 2, 2);
    do_probe("probe_x255", 255, 3);
    do_probe("probe_y_edge", 4, MAP_HEIGHT);
    for (int i = 0; i < 20; i++)
      do_probe("probe_rand", $urandom_range(0, 63), $urandom_range(0, 63));

    // req held 9 cycles -> one probe every 3 cycles
    acks = 0;
    probe_x = 8'd10; probe_y = 8'd40; probe_req = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      if (probe_ack) acks++;
    end
    probe_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (probe_ack) acks++;
    end
    check("burst_acks", acks, 3);
    check("burst_tile", probe_tile, TEST);

    // req dropped while in READ still completes
    probe_x = 8'd5; probe_y = 8'd6; probe_req = 1'b1;
    step();
    probe_req = 1'b0;
    step();
    check("no_abort_ack", probe_ack, 1);
    check("no_abort_tile", probe_tile, PLAYER1);
    step();

    // Reset mid-line and mid-probe
    hcount_in = 11'd100; vcount_in = 11'd100; hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'h999;
    step(); step();
    probe_x = 8'd5; probe_y = 8'd6; probe_req = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rgb", rgb_out, 0);
    check("midrst_counts", {hcount_out, vcount_out}, 0);
    check("midrst_timing", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    check("midrst_probe", {probe_ack, probe_hit}, 0);
    check("midrst_probe_tile", probe_tile, EMPTY);
    probe_req = 1'b0;
    step();
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (probe_ack) acks++;
    end
    check("dropped_probe_no_ack", acks, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
